program_loader: RTL and testbench

Byte-stream program loader that writes images into the processor's 256-byte instruction/data memory and holds the processor in reset until a valid image is in place. It accepts framed bytes over a valid/ready handshake and issues single-cycle memory writes on the same port the processor's manual-write path uses. It is the writer counterpart to the control unit's fetch path, which reads memory starting at PC 0. It also reports frame completion and checksum or timeout errors.

---
 rtl/program_loader.sv | 151 +++++++++++++++
 tb/tb_program_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes images into the 256-byte memory
// and holds the processor in reset until a checksummed frame lands.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    stream byte and its valid flag
//   in_ready            always 1 once out of reset (no back-pressure)
//   mem_addr/mem_data   registered write address/data (held when idle)
//   mem_we              one-cycle write pulse per payload byte
//   cpu_hold            processor hold; released only after a good frame
//   done/err            status of the last frame (mutually exclusive)
module program_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        ready_q;
    logic [15:0] idle;
    logic [7:0]  base;
    logic [7:0]  idx;
    logic [7:0]  cnt;
    logic [7:0]  csum;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic        we_q;

    logic accept;
    logic in_frame;
    logic timeout_hit;

    assign accept   = in_valid & ready_q;
    assign in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                      (state == ST_DATA) || (state == ST_CSUM);
    // Fires on the edge where the idle count would reach TIMEOUT;
    // an accepted byte on that same edge takes priority.
    assign timeout_hit = in_frame && !accept &&
                         (idle == TIMEOUT - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = ready_q;
        mem_addr = addr_q;
        mem_data = data_q;
        mem_we   = we_q;
        done     = (state == ST_DONE);
        err      = (state == ST_ERR);
        cpu_hold = (state != ST_DONE);
        if (timeout_hit) begin
            state_nx = ST_ERR;
        end else if (accept) begin
            case (state)
                ST_SYNC, ST_DONE, ST_ERR: begin
                    if (in_data == SYNC_BYTE) begin
                        state_nx = ST_ADDR;
                    end
                end
                ST_ADDR: state_nx = ST_LEN;
                ST_LEN: begin
                    state_nx = (in_data == 8'h00) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    if (cnt == 8'h01) begin
                        state_nx = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_nx = (in_data == csum) ? ST_DONE : ST_ERR;
                end
                default: state_nx = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            idle    <= 16'd0;
            base    <= 8'h00;
            idx     <= 8'h00;
            cnt     <= 8'h00;
            csum    <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            we_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            if (!in_frame || accept || timeout_hit) begin
                idle <= 16'd0;
            end else begin
                idle <= idle + 16'd1;
            end
            if (accept) begin
                case (state)
                    ST_ADDR: begin
                        base <= in_data;
                        csum <= in_data;
                        idx  <= 8'h00;
                    end
                    ST_LEN: begin
                        cnt  <= in_data;
                        csum <= csum ^ in_data;
                    end
                    ST_DATA: begin
                        // 8-bit add wraps 0xFF back to 0x00
                        addr_q <= base + idx;
                        data_q <= in_data;
                        we_q   <= 1'b1;
                        csum   <= csum ^ in_data;
                        idx    <= idx + 8'h01;
                        cnt    <= cnt - 8'h01;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader with TIMEOUT shortened to 8.
// Each vector drives one byte slot and checks outputs after the edge.
module tb_program_loader;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       cpu_hold;
    logic       done;
    logic       err;

    program_loader #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT(16'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       dn;
        logic       er;
        logic       hold;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    // {ready, we, addr, data, done, err, hold}
    function automatic logic [20:0] pack_out();
        return {in_ready, mem_we, mem_addr, mem_data, done, err, cpu_hold};
    endfunction

    task automatic check(input string name, input int n,
                         input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s #%0d got %h exp %h", name, n, got, exp);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic v,
                       input logic we, input logic [7:0] a,
                       input logic [7:0] dt, input logic dn,
                       input logic er, input logic h);
        vec_t t;
        t.d = d; t.v = v; t.we = we; t.addr = a; t.data = dt;
        t.dn = dn; t.er = er; t.hold = h;
        vecs.push_back(t);
    endtask

    // Accepted bytes that only advance framing: no write, busy status.
    task automatic busy(input logic [7:0] d, input logic [7:0] a,
                        input logic [7:0] dt);
        add(d, 1'b1, 1'b0, a, dt, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run(input string name);
        logic [20:0] exp;
        for (int i = 0; i < vecs.size(); i++) begin
            in_data  = vecs[i].d;
            in_valid = vecs[i].v;
            @(negedge clk);
            exp = {1'b1, vecs[i].we, vecs[i].addr, vecs[i].data,
                   vecs[i].dn, vecs[i].er, vecs[i].hold};
            check(name, i, pack_out(), exp);
        end
        in_valid = 1'b0;
        vecs.delete();
    endtask

    localparam logic [20:0] RST_OUT = {1'b0, 1'b0, 8'h00, 8'h00,
                                       1'b0, 1'b0, 1'b1};

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #3;
        check("reset", 0, pack_out(), RST_OUT);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("ready_pre", 0, {20'd0, in_ready}, 21'd0);
        @(negedge clk);
        check("ready_post", 0, {20'd0, in_ready}, 21'd1);

        // Basic frame
        busy(8'hA5, 8'h00, 8'h00);
        busy(8'h10, 8'h00, 8'h00);
        busy(8'h02, 8'h00, 8'h00);
        add(8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 1);
        add(8'h33, 1, 1, 8'h11, 8'h33, 0, 0, 1);
        add(8'h01, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        add(8'hA5, 0, 0, 8'h11, 8'h33, 1, 0, 0);
        // Address wrap
        busy(8'hA5, 8'h11, 8'h33);
        busy(8'hFF, 8'h11, 8'h33);
        busy(8'h02, 8'h11, 8'h33);
        add(8'hAA, 1, 1, 8'hFF, 8'hAA, 0, 0, 1);
        add(8'hBB, 1, 1, 8'h00, 8'hBB, 0, 0, 1);
        add(8'hEC, 1, 0, 8'h00, 8'hBB, 1, 0, 0);
        // Bad checksum
        busy(8'hA5, 8'h00, 8'hBB);
        busy(8'h10, 8'h00, 8'hBB);
        busy(8'h02, 8'h00, 8'hBB);
        add(8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 1);
        add(8'h33, 1, 1, 8'h11, 8'h33, 0, 0, 1);
        add(8'h00, 1, 0, 8'h11, 8'h33, 0, 1, 1);
        // Empty frame, wrong checksum (20^00 = 20)
        busy(8'hA5, 8'h11, 8'h33);
        busy(8'h20, 8'h11, 8'h33);
        busy(8'h00, 8'h11, 8'h33);
        add(8'h22, 1, 0, 8'h11, 8'h33, 0, 1, 1);
        // Empty frame, good checksum
        busy(8'hA5, 8'h11, 8'h33);
        busy(8'h20, 8'h11, 8'h33);
        busy(8'h00, 8'h11, 8'h33);
        add(8'h20, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        // Garbage then frame
        add(8'h00, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        add(8'hFF, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        add(8'h5A, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        busy(8'hA5, 8'h11, 8'h33);
        busy(8'h40, 8'h11, 8'h33);
        busy(8'h01, 8'h11, 8'h33);
        add(8'h77, 1, 1, 8'h40, 8'h77, 0, 0, 1);
        add(8'h36, 1, 0, 8'h40, 8'h77, 1, 0, 0);
        run("frames");

        // Timeout: err exactly 8 edges after the last byte
        busy(8'hA5, 8'h40, 8'h77);
        busy(8'h10, 8'h40, 8'h77);
        busy(8'h02, 8'h40, 8'h77);
        add(8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 1);
        for (int i = 0; i < 7; i++) add(8'h33, 0, 0, 8'h10, 8'h20, 0, 0, 1);
        add(8'h33, 0, 0, 8'h10, 8'h20, 0, 1, 1);
        add(8'h33, 0, 0, 8'h10, 8'h20, 0, 1, 1);
        run("timeout");

        // Byte arriving on the timeout edge wins
        busy(8'hA5, 8'h10, 8'h20);
        busy(8'h10, 8'h10, 8'h20);
        busy(8'h02, 8'h10, 8'h20);
        add(8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 1);
        for (int i = 0; i < 7; i++) add(8'h00, 0, 0, 8'h10, 8'h20, 0, 0, 1);
        add(8'h33, 1, 1, 8'h11, 8'h33, 0, 0, 1);
        for (int i = 0; i < 7; i++) add(8'h00, 0, 0, 8'h11, 8'h33, 0, 0, 1);
        add(8'h01, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        run("edge_win");

        // Reset mid-payload
        busy(8'hA5, 8'h11, 8'h33);
        busy(8'h10, 8'h11, 8'h33);
        busy(8'h03, 8'h11, 8'h33);
        add(8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 1);
        run("pre_rst");
        in_data  = 8'h33;
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst", 0, pack_out(), RST_OUT);
        @(negedge clk);
        check("rst_held", 0, pack_out(), RST_OUT);
        in_valid = 1'b0;
        rst = 1'b0;
        check("rst_ready0", 0, {20'd0, in_ready}, 21'd0);
        @(negedge clk);
        check("rst_ready1", 0, pack_out(),
              {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});

        busy(8'hA5, 8'h00, 8'h00);
        busy(8'h10, 8'h00, 8'h00);
        busy(8'h02, 8'h00, 8'h00);
        add(8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 1);
        add(8'h33, 1, 1, 8'h11, 8'h33, 0, 0, 1);
        add(8'h01, 1, 0, 8'h11, 8'h33, 1, 0, 0);
        run("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
